// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter granting four requesters access to one shared
// register-file read mux, with a registered valid/ready response.
module regfile_read_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [19:0] req_addr,
    output logic [3:0]  grant,
    output logic [4:0]  mux_address,
    input  logic [31:0] mux_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_id,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        ptr_q;
    logic [1:0]        win_q;
    logic [4:0]        addr_q;
    logic [31:0]       data_q;
    logic [1:0]        id_q;
    logic              arb_en;
    logic [1:0]        pick;
    logic [1:0]        cand;
    logic [3:0][4:0]   addrs;

    assign addrs = req_addr;

    // Descending scan so the requester nearest ptr is written last and wins.
    always_comb begin
        pick = ptr_q;
        cand = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) pick = cand;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        arb_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    arb_en  = 1'b1;
                    state_d = SELECT;
                end
            end
            SELECT: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (|req) begin
                        arb_en  = 1'b1;
                        state_d = SELECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant     = '0;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        if (state_q == SELECT) grant[win_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            win_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            id_q   <= '0;
        end else begin
            if (arb_en) begin
                win_q  <= pick;
                addr_q <= addrs[pick];
            end
            if (state_q == SELECT) begin
                data_q <= mux_data;
                id_q   <= win_q;
                ptr_q  <= win_q + 2'd1;
            end
        end
    end

    assign mux_address = addr_q;
    assign rsp_data    = data_q;
    assign rsp_id      = id_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed vector table, reset
// sequences, and randomized transactions against a round-robin model.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic [3:0]  grant;
    logic [4:0]  mux_address;
    logic [31:0] mux_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        busy;

    logic [31:0] mem [32];
    int          n_chk = 0;
    int          n_pass = 0;
    int          model_ptr = 0;

    assign mux_data = mem[mux_address];

    always #5 clk = ~clk;

    regfile_read_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .grant      (grant),
        .mux_address(mux_address),
        .mux_data   (mux_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    typedef struct {
        logic [3:0]  req;
        logic [19:0] addr;
        int          stall;
        bit          idle_after;
        logic [3:0]  exp_grant;
        logic [4:0]  exp_maddr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration: sample edge, SELECT cycle, RESP with stall cycles.
    task automatic run_txn(input logic [3:0] r, input logic [19:0] a,
                           input int stall, input bit idle_after,
                           input logic [3:0] eg, input logic [4:0] ema,
                           input string tag);
        int w;
        logic [31:0] ed;
        w = 0;
        for (int i = 0; i < 4; i++) if (eg[i]) w = i;
        req = r;
        req_addr = a;
        rsp_ready = 1'b1;
        tick();
        req_addr = $urandom;
        req = 4'($urandom);
        chk({tag, " grant"}, grant, eg);
        chk({tag, " mux_address"}, mux_address, ema);
        chk({tag, " valid_in_select"}, rsp_valid, 0);
        chk({tag, " busy_in_select"}, busy, 1);
        ed = mem[ema];
        model_ptr = (w + 1) % 4;
        rsp_ready = (stall == 0);
        tick();
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_id"}, rsp_id, w);
        chk({tag, " rsp_data"}, rsp_data, ed);
        chk({tag, " grant_in_resp"}, grant, 0);
        for (int s = 0; s < stall; s++) begin
            mem[ema] = $urandom;
            req = 4'($urandom);
            tick();
            chk({tag, " stall_valid"}, rsp_valid, 1);
            chk({tag, " stall_id"}, rsp_id, w);
            chk({tag, " stall_data"}, rsp_data, ed);
            chk({tag, " stall_grant"}, grant, 0);
            chk({tag, " stall_maddr"}, mux_address, ema);
        end
        rsp_ready = 1'b1;
        if (idle_after) begin
            req = 4'b0000;
            tick();
            chk({tag, " idle_valid"}, rsp_valid, 0);
            chk({tag, " idle_busy"}, busy, 0);
            chk({tag, " idle_grant"}, grant, 0);
            chk({tag, " idle_maddr"}, mux_address, ema);
        end
    endtask

    vec_t        vecs [10];
    logic [3:0]  cur_req;
    logic [3:0][4:0] addrs;
    int          w;
    int          j;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[17] = 32'hDEAD_BEEF;
        mem[0]  = 32'h0000_A5A0;
        mem[31] = 32'h3131_F00D;

        vecs[0] = '{4'b0100, {5'd0, 5'd17, 5'd0, 5'd0}, 0, 1, 4'b0100, 5'd17};
        vecs[1] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 0, 0, 4'b0001, 5'd0};
        vecs[2] = '{4'b1000, {5'd31, 5'd0, 5'd0, 5'd0}, 5, 0, 4'b1000, 5'd31};
        vecs[3] = '{4'b1111, {5'd9, 5'd5, 5'd22, 5'd11}, 0, 0, 4'b0001, 5'd11};
        vecs[4] = '{4'b1111, {5'd9, 5'd5, 5'd22, 5'd11}, 0, 0, 4'b0010, 5'd22};
        vecs[5] = '{4'b1111, {5'd9, 5'd5, 5'd22, 5'd11}, 0, 0, 4'b0100, 5'd5};
        vecs[6] = '{4'b1111, {5'd9, 5'd5, 5'd22, 5'd11}, 0, 0, 4'b1000, 5'd9};
        vecs[7] = '{4'b1111, {5'd9, 5'd5, 5'd22, 5'd11}, 0, 1, 4'b0001, 5'd11};
        vecs[8] = '{4'b0011, {5'd0, 5'd0, 5'd7, 5'd3}, 0, 0, 4'b0010, 5'd7};
        vecs[9] = '{4'b0011, {5'd0, 5'd0, 5'd7, 5'd3}, 0, 1, 4'b0001, 5'd3};

        reset = 1'b0;
        req = '0;
        req_addr = '0;
        rsp_ready = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("reset grant", grant, 0);
        chk("reset valid", rsp_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset maddr", mux_address, 0);
        chk("reset id", rsp_id, 0);
        chk("reset data", rsp_data, 0);
        tick();
        tick();
        #2 reset = 1'b0;
        model_ptr = 0;

        for (int i = 0; i < 10; i++)
            run_txn(vecs[i].req, vecs[i].addr, vecs[i].stall,
                    vecs[i].idle_after, vecs[i].exp_grant,
                    vecs[i].exp_maddr, $sformatf("vec%0d", i));

        // Reset between edges while in SELECT.
        req = 4'b0010;
        req_addr = {5'd0, 5'd0, 5'd13, 5'd0};
        rsp_ready = 1'b1;
        tick();
        chk("pre_reset grant", grant, 4'b0010);
        #2 reset = 1'b1;
        #1;
        chk("async grant", grant, 0);
        chk("async valid", rsp_valid, 0);
        chk("async busy", busy, 0);
        chk("async maddr", mux_address, 0);
        req = '0;
        tick();
        tick();
        #2 reset = 1'b0;
        tick();
        chk("post_reset grant", grant, 0);
        chk("post_reset valid", rsp_valid, 0);
        chk("post_reset busy", busy, 0);
        model_ptr = 0;
        run_txn(4'b0011, {5'd0, 5'd0, 5'd4, 5'd26}, 0, 0, 4'b0001, 5'd26,
                "rst_ptr0");
        run_txn(4'b1000, {5'd20, 5'd0, 5'd0, 5'd0}, 1, 1, 4'b1000, 5'd20,
                "rst_req3");

        // Randomized transactions checked against the round-robin model.
        cur_req = '0;
        addrs = '0;
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (!cur_req[i] && $urandom_range(0, 1) == 1) begin
                    cur_req[i] = 1'b1;
                    addrs[i] = 5'($urandom);
                end
            end
            if (cur_req == 4'b0000) begin
                j = $urandom_range(0, 3);
                cur_req[j] = 1'b1;
                addrs[j] = 5'($urandom);
            end
            w = rr_pick(cur_req, model_ptr);
            run_txn(cur_req, addrs, $urandom_range(0, 3),
                    $urandom_range(0, 3) == 0, 4'(1 << w), addrs[w],
                    $sformatf("rnd%0d", t));
            cur_req[w] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: req  input  4  per-requester read request, bit i = requester i.
REQ-004 SHALL have ports: req_addr  input  20  requester i register address at bits [5i+4:5i].
REQ-005 SHALL have ports: grant  output  4  one-hot, one-cycle pulse acknowledging the winning request.
REQ-006 SHALL have ports: mux_address  output  5  drives address select of the shared 32x32 read mux.
REQ-007 SHALL have ports: mux_data  input  32  data returned by the shared read mux, combinational in mux_address.
REQ-008 SHALL have ports: rsp_valid  output  1  response available.
REQ-009 SHALL have ports: rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have ports: rsp_id  output  2  index of requester owning the response.
REQ-011 SHALL have ports: rsp_data  output  32  registered read data.
REQ-012 SHALL have ports: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SELECT, RESP.
REQ-014 IDLE: if req != 0, SHALL pick the winner by round-robin, latch its index and 5-bit address, go SELECT; else stay IDLE.
REQ-015 Round-robin: search starts at priority pointer ptr, ascending, wrapping 3->0; first set req bit wins.
REQ-016 SELECT: mux_address SHALL equal the latched address for the whole cycle; grant[winner] SHALL be 1 for exactly this cycle; rsp_data <= mux_data, rsp_id <= winner at cycle end; ptr <= (winner+1) mod 4; go RESP.
REQ-017 RESP: rsp_valid SHALL be 1; rsp_data and rsp_id SHALL hold stable until accepted.
REQ-018 RESP with rsp_ready=1 and req=0 SHALL go IDLE.
REQ-019 RESP with rsp_ready=1 and req!=0 SHALL arbitrate per REQ-014/015 with the updated ptr and go directly to SELECT (sustained throughput one read per 2 cycles).
REQ-020 RESP with rsp_ready=0 SHALL remain in RESP regardless of req.
REQ-021 Latency: req sampled in IDLE at edge N -> grant high in cycle N+1 -> rsp_valid high from cycle N+2.
REQ-022 Requesters hold req and req_addr until grant; a req bit dropped before grant SHALL be ignored with no side effects.
REQ-023 req_addr changes after the latch edge SHALL NOT affect mux_address or rsp_data of the current transaction.
REQ-024 Outside SELECT, mux_address SHALL hold its last latched value (no glitching to other addresses).
REQ-025 grant SHALL be 0 in IDLE and RESP; at most one grant bit high in any cycle.
REQ-026 Address 0..31 SHALL all be passed through unmodified; no special case for any register.

Reset
REQ-027 reset high SHALL immediately force state IDLE, ptr=0, grant=0, mux_address=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
REQ-028 reset asserted mid-transaction (SELECT or RESP) SHALL discard the pending response; no grant or rsp_valid after reset deasserts until a new req is sampled.
REQ-029 First arbitration after reset SHALL favour requester 0.

Verification
REQ-030 Single request: req=4'b0100, addr2=5'd17, mux returns 0xDEAD_BEEF for address 17, rsp_ready=1 -> grant=4'b0100 one cycle after request, rsp_valid next cycle with rsp_id=2, rsp_data=0xDEAD_BEEF.
REQ-031 Round-robin fairness: req=4'b1111 held, rsp_ready=1 -> grant sequence 0,1,2,3,0 on every other cycle, mux_address following each requester's addr.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP while mux_data changes -> rsp_valid, rsp_id, rsp_data unchanged; no new grant until rsp_ready=1.
REQ-033 Back-to-back: req=4'b0011, ptr=1 -> grants 1 then 0; rsp_valid deasserts for the SELECT cycle between responses.
REQ-034 Async reset in SELECT: assert reset between edges -> grant, rsp_valid, busy fall to 0 without a clock edge; after release with req=4'b1000, grant=4'b1000 and ptr restarts at 0.
REQ-035 Address boundary: addr=5'd0 and addr=5'd31 -> mux_address 0 and 31, rsp_data equals mux_data for each.
